// File: rtl/ild1420_pkg.sv
// rtl/ild1420_pkg.sv - shared constants, flags and state enums for the ILD1420 frame decoder
package ild1420_pkg;

    localparam int DIST_W = 18;

    localparam logic [1:0] FLAG_L = 2'b00;
    localparam logic [1:0] FLAG_M = 2'b01;
    localparam logic [1:0] FLAG_H = 2'b10;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        ASM_WAIT_L,
        ASM_WAIT_M,
        ASM_WAIT_H
    } asm_state_t;

endpackage

// File: rtl/ild1420_uart_rx.sv
// rtl/ild1420_uart_rx.sv - rx synchronizer and 8N1 UART receive state machine
module ild1420_uart_rx
    import ild1420_pkg::*;
#(
    parameter int MIN_CPB = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rx,
    input  logic        i_enable,
    input  logic [15:0] i_clks_per_bit,
    output logic [7:0]  o_byte,
    output logic        o_byte_valid,
    output logic        o_frame_err
);

    rx_state_t   r_state;
    rx_state_t   w_state_nxt;
    logic [1:0]  r_sync;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  w_bit_nxt;
    logic [15:0] r_period;
    logic [15:0] w_period_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic        w_rx;
    logic [15:0] w_period_sel;
    logic        w_half_tick;
    logic        w_full_tick;

    assign w_rx         = r_sync[1];
    assign w_period_sel = (i_clks_per_bit < 16'(MIN_CPB)) ? 16'(MIN_CPB) : i_clks_per_bit;
    assign w_half_tick  = (r_cnt == (r_period >> 1) - 16'd1);
    assign w_full_tick  = (r_cnt == r_period - 16'd1);
    assign o_byte       = r_shift;

    // two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_rx};
        end
    end

    // receiver state, bit timing and shift register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_period  <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_period  <= w_period_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    // next-state: start half a period in, then one sample per period; stop returns to idle at once
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + 16'd1;
        w_bit_nxt    = r_bit_cnt;
        w_period_nxt = r_period;
        w_shift_nxt  = r_shift;
        o_byte_valid = 1'b0;
        o_frame_err  = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rx) begin
                    w_state_nxt  = RX_START;
                    w_period_nxt = w_period_sel;
                end
            end
            RX_START: begin
                if (w_half_tick) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = w_rx ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_full_tick) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rx, r_shift[7:1]};
                    w_bit_nxt   = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (w_full_tick) begin
                    w_cnt_nxt    = '0;
                    w_state_nxt  = RX_IDLE;
                    o_byte_valid = w_rx;
                    o_frame_err  = !w_rx;
                end
            end
            default: begin
                w_state_nxt = RX_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        if (!i_enable) begin
            w_state_nxt  = RX_IDLE;
            w_cnt_nxt    = '0;
            w_bit_nxt    = '0;
            o_byte_valid = 1'b0;
            o_frame_err  = 1'b0;
        end
    end

endmodule

// File: rtl/ild1420_frame_decoder.sv
// rtl/ild1420_frame_decoder.sv - assembles L/M/H UART bytes into distance samples with error counters
module ild1420_frame_decoder
    import ild1420_pkg::*;
#(
    parameter int DIST_W  = ild1420_pkg::DIST_W,
    parameter int MIN_CPB = 4
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              rx,
    input  logic              enable,
    input  logic [15:0]       clks_per_bit,
    input  logic              err_clear,
    output logic [DIST_W-1:0] dist_data,
    output logic              dist_valid,
    output logic [7:0]        frame_err_count,
    output logic [7:0]        seq_err_count
);

    asm_state_t        r_asm;
    asm_state_t        w_asm_nxt;
    logic [7:0]        w_byte;
    logic              w_byte_valid;
    logic              w_frame_err;
    logic [1:0]        w_flag;
    logic              w_store_l;
    logic              w_store_m;
    logic              w_load;
    logic              w_seq_err;
    logic [5:0]        r_l;
    logic [5:0]        r_m;
    logic [17:0]       w_dist_full;
    logic [DIST_W-1:0] r_dist;
    logic              r_valid;
    logic [7:0]        r_ferr_cnt;
    logic [7:0]        r_seq_cnt;

    ild1420_uart_rx #(
        .MIN_CPB (MIN_CPB)
    ) u_uart_rx (
        .i_clk          (ACLK),
        .i_rst_n        (ARESETN),
        .i_rx           (rx),
        .i_enable       (enable),
        .i_clks_per_bit (clks_per_bit),
        .o_byte         (w_byte),
        .o_byte_valid   (w_byte_valid),
        .o_frame_err    (w_frame_err)
    );

    assign w_flag          = w_byte[7:6];
    assign w_dist_full     = {w_byte[5:0], r_m, r_l};
    assign dist_data       = r_dist;
    assign dist_valid      = r_valid;
    assign frame_err_count = r_ferr_cnt;
    assign seq_err_count   = r_seq_cnt;

    // assembler state register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_asm <= ASM_WAIT_L;
        end else begin
            r_asm <= w_asm_nxt;
        end
    end

    // assembler next-state: a stray L byte restarts the frame, anything else unexpected drops it
    always_comb begin
        w_asm_nxt = r_asm;
        w_store_l = 1'b0;
        w_store_m = 1'b0;
        w_load    = 1'b0;
        w_seq_err = 1'b0;
        if (!enable || w_frame_err) begin
            w_asm_nxt = ASM_WAIT_L;
        end else if (w_byte_valid) begin
            case (r_asm)
                ASM_WAIT_L: begin
                    if (w_flag == FLAG_L) begin
                        w_store_l = 1'b1;
                        w_asm_nxt = ASM_WAIT_M;
                    end else begin
                        w_seq_err = 1'b1;
                        w_asm_nxt = ASM_WAIT_L;
                    end
                end
                ASM_WAIT_M: begin
                    w_seq_err = (w_flag != FLAG_M);
                    if (w_flag == FLAG_M) begin
                        w_store_m = 1'b1;
                        w_asm_nxt = ASM_WAIT_H;
                    end else if (w_flag == FLAG_L) begin
                        w_store_l = 1'b1;
                        w_asm_nxt = ASM_WAIT_M;
                    end else begin
                        w_asm_nxt = ASM_WAIT_L;
                    end
                end
                ASM_WAIT_H: begin
                    w_seq_err = (w_flag != FLAG_H);
                    if (w_flag == FLAG_H) begin
                        w_load    = 1'b1;
                        w_asm_nxt = ASM_WAIT_L;
                    end else if (w_flag == FLAG_L) begin
                        w_store_l = 1'b1;
                        w_asm_nxt = ASM_WAIT_M;
                    end else begin
                        w_asm_nxt = ASM_WAIT_L;
                    end
                end
                default: begin
                    w_asm_nxt = ASM_WAIT_L;
                end
            endcase
        end
    end

    // partial-frame storage and the registered distance output
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_l     <= '0;
            r_m     <= '0;
            r_dist  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_store_l) r_l <= w_byte[5:0];
            if (w_store_m) r_m <= w_byte[5:0];
            if (w_load)    r_dist <= DIST_W'(w_dist_full);
            r_valid <= w_load;
        end
    end

    // saturating error counters; a clear overrides a same-cycle increment
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_ferr_cnt <= '0;
            r_seq_cnt  <= '0;
        end else if (err_clear) begin
            r_ferr_cnt <= '0;
            r_seq_cnt  <= '0;
        end else begin
            if (w_frame_err && r_ferr_cnt != 8'hFF) r_ferr_cnt <= r_ferr_cnt + 8'd1;
            if (w_seq_err && r_seq_cnt != 8'hFF)    r_seq_cnt  <= r_seq_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_ild1420_frame_decoder.sv
// tb/tb_ild1420_frame_decoder.sv - scoreboard bench for the ILD1420 frame decoder
module tb_ild1420_frame_decoder;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        rx;
    logic        enable;
    logic [15:0] clks_per_bit;
    logic        err_clear;
    logic [17:0] dist_data;
    logic        dist_valid;
    logic [7:0]  frame_err_count;
    logic [7:0]  seq_err_count;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_valid = 0;
    int          n_pushed = 0;
    int          bench_cpb = 10;
    logic        prev_valid = 1'b0;
    logic [17:0] exp_q[$];
    logic [17:0] exp_v;
    logic [17:0] held;

    always #5 ACLK = ~ACLK;

    ild1420_frame_decoder #(
        .DIST_W  (18),
        .MIN_CPB (4)
    ) dut (
        .ACLK            (ACLK),
        .ARESETN         (ARESETN),
        .rx              (rx),
        .enable          (enable),
        .clks_per_bit    (clks_per_bit),
        .err_clear       (err_clear),
        .dist_data       (dist_data),
        .dist_valid      (dist_valid),
        .frame_err_count (frame_err_count),
        .seq_err_count   (seq_err_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] model_dist(input logic [7:0] l, input logic [7:0] m, input logic [7:0] h);
        return {h[5:0], m[5:0], l[5:0]};
    endfunction

    task automatic wait_bits(input int n);
        repeat (n * bench_cpb) @(negedge ACLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_bits(1);
        end
        rx = stop_bit;
        wait_bits(1);
        rx = 1'b1;
        wait_bits(2);
    endtask

    task automatic send_triple(input logic [7:0] l, input logic [7:0] m, input logic [7:0] h, input logic expect_out);
        send_byte(l, 1'b1);
        send_byte(m, 1'b1);
        if (expect_out) begin
            exp_q.push_back(model_dist(l, m, h));
            n_pushed++;
        end
        send_byte(h, 1'b1);
    endtask

    // scoreboard: pop the oldest expected sample on each strobe
    always @(negedge ACLK) begin
        if (ARESETN && dist_valid) begin
            n_valid++;
            chk("dv_double", {31'd0, prev_valid}, 32'd0);
            chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                chk("dist_data", {14'd0, dist_data}, {14'd0, exp_v});
            end
        end
        prev_valid <= ARESETN && dist_valid;
    end

    initial begin
        ARESETN      = 1'b0;
        rx           = 1'b1;
        enable       = 1'b1;
        clks_per_bit = 16'd10;
        err_clear    = 1'b0;
        repeat (5) @(negedge ACLK);
        chk("rst_dist", {14'd0, dist_data}, 32'd0);
        chk("rst_valid", {31'd0, dist_valid}, 32'd0);
        chk("rst_ferr", {24'd0, frame_err_count}, 32'd0);
        chk("rst_serr", {24'd0, seq_err_count}, 32'd0);
        ARESETN = 1'b1;
        wait_bits(2);

        // good frame
        send_byte(8'h05, 1'b1);
        send_byte(8'h4A, 1'b1);
        exp_q.push_back(18'h03285);
        n_pushed++;
        send_byte(8'h83, 1'b1);
        chk("good_q_empty", exp_q.size(), 32'd0);
        chk("good_ferr", {24'd0, frame_err_count}, 32'd0);
        chk("good_serr", {24'd0, seq_err_count}, 32'd0);

        // framing error on the M byte, then recovery
        send_byte(8'h05, 1'b1);
        send_byte(8'h4A, 1'b0);
        send_byte(8'h83, 1'b1);
        chk("ferr_count", {24'd0, frame_err_count}, 32'd1);
        chk("ferr_serr", {24'd0, seq_err_count}, 32'd1);
        send_triple(8'h05, 8'h4A, 8'h83, 1'b1);

        // sequence error: L followed directly by H
        send_byte(8'h05, 1'b1);
        send_byte(8'h83, 1'b1);
        chk("seq_count", {24'd0, seq_err_count}, 32'd2);
        send_triple(8'h05, 8'h4A, 8'h83, 1'b1);
        chk("seq_after", {24'd0, seq_err_count}, 32'd2);

        // two-cycle glitch is not a start bit
        rx = 1'b0;
        repeat (2) @(negedge ACLK);
        rx = 1'b1;
        wait_bits(3);
        chk("glitch_ferr", {24'd0, frame_err_count}, 32'd1);
        chk("glitch_serr", {24'd0, seq_err_count}, 32'd2);

        // period below the minimum is raised to MIN_CPB
        clks_per_bit = 16'd2;
        bench_cpb    = 4;
        send_triple(8'h3F, 8'h55, 8'hAA, 1'b1);
        clks_per_bit = 16'd10;
        bench_cpb    = 10;
        chk("mincpb_dist", {14'd0, dist_data}, 32'h2A57F);

        // disabled decoder ignores traffic and retains state
        held   = dist_data;
        enable = 1'b0;
        send_triple(8'h01, 8'h42, 8'h83, 1'b0);
        enable = 1'b1;
        wait_bits(1);
        chk("dis_dist", {14'd0, dist_data}, {14'd0, held});
        chk("dis_serr", {24'd0, seq_err_count}, 32'd2);

        // reset during the M byte
        send_byte(8'h05, 1'b1);
        rx = 1'b0;
        wait_bits(1);
        rx = 1'b1;
        wait_bits(1);
        rx = 1'b0;
        wait_bits(1);
        ARESETN = 1'b0;
        rx      = 1'b1;
        repeat (3) @(negedge ACLK);
        chk("mrst_dist", {14'd0, dist_data}, 32'd0);
        chk("mrst_ferr", {24'd0, frame_err_count}, 32'd0);
        chk("mrst_serr", {24'd0, seq_err_count}, 32'd0);
        ARESETN = 1'b1;
        wait_bits(3);
        send_triple(8'h05, 8'h4A, 8'h83, 1'b1);
        chk("mrst_ferr2", {24'd0, frame_err_count}, 32'd0);
        chk("mrst_serr2", {24'd0, seq_err_count}, 32'd0);

        // saturation, then clear
        clks_per_bit = 16'd4;
        bench_cpb    = 4;
        for (int i = 0; i < 300; i++) send_byte(8'hC0, 1'b1);
        chk("sat_serr", {24'd0, seq_err_count}, 32'd255);
        err_clear = 1'b1;
        @(negedge ACLK);
        err_clear = 1'b0;
        chk("clr_serr", {24'd0, seq_err_count}, 32'd0);
        chk("clr_ferr", {24'd0, frame_err_count}, 32'd0);

        wait_bits(2);
        chk("final_q_empty", exp_q.size(), 32'd0);
        chk("valid_total", n_valid, n_pushed);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ild1420_frame_decoder.md
ILD1420_FRAME_DECODER -- requirements
Module: ild1420_frame_decoder

Interface
REQ-001 SHALL have parameter DIST_W, default 18, meaning width of the assembled distance word.
REQ-002 SHALL have parameter MIN_CPB, default 4, meaning the minimum clocks-per-bit honoured.
REQ-003 SHALL have port ACLK  input  1  sole clock; all logic is on the rising edge.
REQ-004 SHALL have port ARESETN  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port rx  input  1  RS-422 receiver output, asynchronous to ACLK, idle high.
REQ-006 SHALL have port enable  input  1  decoder enable, from the AXI register block.
REQ-007 SHALL have port clks_per_bit  input  16  ACLK cycles per UART bit.
REQ-008 SHALL have port err_clear  input  1  single-cycle pulse that clears both error counters.
REQ-009 SHALL have port dist_data  output  DIST_W  last complete distance sample.
REQ-010 SHALL have port dist_valid  output  1  one-cycle strobe marking a new dist_data.
REQ-011 SHALL have port frame_err_count  output  8  saturating count of bad stop bits.
REQ-012 SHALL have port seq_err_count  output  8  saturating count of byte-order violations.

Function
REQ-013 SHALL pass rx through a 2-FF synchronizer, both flops reset to 1, before any use.
REQ-014 SHALL receive UART 8N1, LSB first; the effective bit period is max(clks_per_bit, MIN_CPB), latched at start-bit detection.
REQ-015 SHALL run an RX FSM IDLE->START->DATA->STOP->IDLE.
- IDLE: synced rx=0 -> START.
- START: sample at period/2; rx=0 -> DATA, rx=1 -> IDLE (glitch, no count).
- DATA: 8 samples spaced one period apart.
- STOP: sample after one more period, then return to IDLE on the same cycle.
REQ-016 SHALL, on a stop sample of 1, emit the byte to the assembler; on 0 SHALL discard it, increment frame_err_count, and force the assembler to WAIT_L.
REQ-017 SHALL decode byte flags [7:6] as follows: 00=L (D[5:0]), 01=M (D[11:6]), 10=H (D[17:12]), 11=invalid.
REQ-018 SHALL run an assembler FSM WAIT_L/WAIT_M/WAIT_H with these transitions:
- Expected flag: store the 6 bits and advance.
- Unexpected flag 00: count a seq error, store it as a new L, go to WAIT_M.
- Any other unexpected flag: count a seq error, go to WAIT_L.
REQ-019 SHALL, on a valid H byte in WAIT_H, load dist_data={H,M,L} and pulse dist_valid exactly 1 cycle after the H stop-sample cycle, then go to WAIT_L.
REQ-020 SHALL hold dist_data between updates; dist_valid SHALL never be high on two consecutive cycles.
REQ-021 SHALL, while enable=0, hold the RX FSM in IDLE and the assembler in WAIT_L, abandon any partial byte or frame, and retain dist_data and both counters.
REQ-022 SHALL saturate both counters at 255.
REQ-023 SHALL clear both counters to 0 on err_clear, even when an increment occurs in the same cycle (clear wins).

Reset
REQ-024 SHALL, while ARESETN=0, force dist_data=0, dist_valid=0, frame_err_count=0, seq_err_count=0, RX FSM=IDLE, assembler=WAIT_L, and bit/period counters=0.
REQ-025 SHALL discard any in-flight byte on reset assertion mid-frame and resume cleanly at the next start bit after release.

Structure
REQ-026 SHALL place the flag constants (FLAG_L/M/H), DIST_W, and the RX and assembler state enums in the shared package ild1420_pkg.
REQ-027 SHALL implement the synchronizer and RX FSM as sub-module ild1420_uart_rx (outputs byte, byte_valid, frame_err); assembly and counters SHALL live in the top module.

Verification
REQ-028 SHALL cover a good frame: clks_per_bit=10, bytes 0x05, 0x4A, 0x83 -> dist_data=0x03285, one dist_valid pulse, both counters 0.
REQ-029 SHALL cover a framing error: stop bit=0 on the M byte -> frame_err_count=1, no dist_valid; the next good triple decodes correctly.
REQ-030 SHALL cover a sequence error: bytes 0x05, 0x83 -> seq_err_count=1, no dist_valid; a following 0x05, 0x4A, 0x83 yields 0x03285.
REQ-031 SHALL cover glitch rejection: rx low for 2 cycles with clks_per_bit=10 -> no byte emitted, counters unchanged.
REQ-032 SHALL cover reset mid-frame: ARESETN low during the M byte -> all outputs 0; after release, a full triple decodes with exactly one dist_valid.
REQ-033 SHALL cover saturation and clear: 300 bytes of 0xC0 -> seq_err_count=255; err_clear pulse -> 0 on the next cycle.
